// File: rtl/reg_file.sv
// reg_file: 2**ADDR_WIDTH x DATA_WIDTH general-purpose register file for the
// miniRISC datapath. Two combinational read ports, one synchronous write port,
// register 0 hardwired to zero, synchronous active-high clear.

// One combinational read port: selects one entry of the flattened register
// array, forcing index 0 to zero regardless of what the storage holds.
module reg_file_rd_port #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 1 << ADDR_WIDTH
) (
  input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs,
  input  logic [ADDR_WIDTH-1:0]               raddr,
  output logic [DATA_WIDTH-1:0]               rdata
);

  // Zero-latency mux; r0 is decoded here rather than relied on in storage,
  // so reads of r0 are zero even before the first reset.
  always_comb begin
    rdata = '0;
    if (raddr != '0) rdata = regs[raddr];
  end

endmodule

module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic                  regwrite,
  input  logic [ADDR_WIDTH-1:0] read_reg1,
  input  logic [ADDR_WIDTH-1:0] read_reg2,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;
  localparam int NUM_RD   = 2;

  typedef struct packed {
    logic                  en;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wr_req_t;

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
  logic [NUM_RD-1:0][ADDR_WIDTH-1:0]   rd_addr;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0]   rd_data;
  wr_req_t                             wr;

  // Writes to r0 are dropped at the request so the storage never has to
  // special-case it.
  assign wr.en   = regwrite && (write_reg != '0);
  assign wr.addr = write_reg;
  assign wr.data = write_data;

  // Storage: reset clears every entry and wins over a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst)        regs          <= '0;
    else if (wr.en) regs[wr.addr] <= wr.data;
  end

  assign rd_addr[0] = read_reg1;
  assign rd_addr[1] = read_reg2;

  // No write bypass: a read of the register being written shows the old
  // value until the edge, the new value right after.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    reg_file_rd_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_REGS   (NUM_REGS)
    ) u_rd (
      .regs  (regs),
      .raddr (rd_addr[p]),
      .rdata (rd_data[p])
    );
  end

  assign read_data1 = rd_data[0];
  assign read_data2 = rd_data[1];

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed scenarios plus randomized traffic against an
// array-based reference of the register file.
module tb_reg_file;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          regwrite = 1'b0;
  logic [DW-1:0] write_data = '0;
  logic [AW-1:0] write_reg = '0;
  logic [AW-1:0] read_reg1 = '0;
  logic [AW-1:0] read_reg2 = '0;
  logic [DW-1:0] read_data1;
  logic [DW-1:0] read_data2;

  int tests = 0;
  int fails = 0;

  // Reference contents; index 0 is never written so it stays zero.
  logic [DW-1:0] model [NR];

  reg_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .write_data (write_data),
    .write_reg  (write_reg),
    .regwrite   (regwrite),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  always #5 clk = ~clk;

  // Apply the register-file rules to the model for the coming edge, then
  // advance to just past that edge.
  task automatic tick();
    if (rst) begin
      for (int i = 0; i < NR; i++) model[i] = '0;
    end else if (regwrite && write_reg != 0) begin
      model[write_reg] = write_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [DW-1:0] got;
    rst = 1'b1; regwrite = 1'b0;
    tick();
    tick();
    // During reset every address reads zero.
    for (int a = 0; a < NR; a++) begin
      read_reg1 = a[AW-1:0]; read_reg2 = 5'(NR - 1 - a);
      #1;
      tests++;
      if (read_data1 !== '0 || read_data2 !== '0) begin
        fails++;
        $display("FAIL reset_hold addr=%0d got %h/%h want 0/0", a, read_data1, read_data2);
      end
    end
    rst = 1'b0;
    regwrite = 1'b1; write_reg = 5; write_data = 32'hDEADBEEF;
    tick();
    write_reg = 12; write_data = 35;
    tick();
    read_reg1 = 5; read_reg2 = 12;
    #1;
    tests++;
    if (read_data1 !== 32'hDEADBEEF || read_data2 !== 32'd35) begin
      fails++;
      $display("FAIL reset_prewrite got %h/%h want deadbeef/00000023", read_data1, read_data2);
    end
    rst = 1'b1; regwrite = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    got = read_data1;
    tests++;
    if (got !== '0 || read_data2 !== '0) begin
      fails++;
      $display("FAIL reset_clear got %h/%h want 0/0", got, read_data2);
    end
  endtask

  task automatic test_basic_write();
    rst = 1'b0; regwrite = 1'b1; write_reg = 12; write_data = 35;
    read_reg1 = 12; read_reg2 = 1;
    tick();
    tests++;
    if (read_data1 !== 32'd35 || read_data2 !== 32'd0) begin
      fails++;
      $display("FAIL basic_write got %0d/%0d want 35/0", read_data1, read_data2);
    end
  endtask

  task automatic test_second_write();
    regwrite = 1'b1; write_reg = 8; write_data = 9;
    read_reg1 = 12; read_reg2 = 3;
    tick();
    tests++;
    if (read_data1 !== 32'd35 || read_data2 !== 32'd0) begin
      fails++;
      $display("FAIL second_write_keep got %0d/%0d want 35/0", read_data1, read_data2);
    end
    regwrite = 1'b0;
    read_reg2 = 8;
    #1;
    tests++;
    if (read_data2 !== 32'd9) begin
      fails++;
      $display("FAIL second_write_comb got %0d want 9", read_data2);
    end
  endtask

  task automatic test_we_low();
    regwrite = 1'b0; write_reg = 12; write_data = 77;
    read_reg1 = 12;
    tick();
    tests++;
    if (read_data1 !== 32'd35) begin
      fails++;
      $display("FAIL we_low got %0d want 35", read_data1);
    end
  endtask

  task automatic test_r0();
    regwrite = 1'b1; write_reg = 0; write_data = 123;
    read_reg1 = 0; read_reg2 = 0;
    tick();
    regwrite = 1'b0;
    tests++;
    if (read_data1 !== '0 || read_data2 !== '0) begin
      fails++;
      $display("FAIL r0_write got %0d/%0d want 0/0", read_data1, read_data2);
    end
  endtask

  task automatic test_same_cycle_and_reset_priority();
    regwrite = 1'b1; write_reg = 20; write_data = 32'hFFFFFFFF;
    read_reg1 = 20; read_reg2 = 20;
    #1;
    tests++;
    if (read_data1 !== '0) begin
      fails++;
      $display("FAIL same_cycle_before got %h want 00000000", read_data1);
    end
    tick();
    tests++;
    if (read_data1 !== 32'hFFFFFFFF || read_data2 !== 32'hFFFFFFFF) begin
      fails++;
      $display("FAIL same_cycle_after got %h/%h want ffffffff/ffffffff", read_data1, read_data2);
    end
    rst = 1'b1; regwrite = 1'b1; write_reg = 20; write_data = 5;
    tick();
    rst = 1'b0; regwrite = 1'b0;
    #1;
    tests++;
    if (read_data1 !== '0) begin
      fails++;
      $display("FAIL reset_priority got %h want 00000000", read_data1);
    end
  endtask

  // Random traffic: each cycle checks both ports before the edge (old
  // contents, no bypass) and after it (updated contents).
  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst        = ($urandom_range(0, 39) == 0);
      regwrite   = ($urandom_range(0, 3) != 0);
      write_reg  = AW'($urandom_range(0, NR - 1));
      write_data = $urandom;
      read_reg1  = ($urandom_range(0, 3) == 0) ? write_reg : AW'($urandom_range(0, NR - 1));
      read_reg2  = ($urandom_range(0, 7) == 0) ? read_reg1 : AW'($urandom_range(0, NR - 1));
      #1;
      tests++;
      if (read_data1 !== model[read_reg1] || read_data2 !== model[read_reg2]) begin
        fails++;
        $display("FAIL rand_pre n=%0d r%0d=%h r%0d=%h want %h/%h", n, read_reg1, read_data1,
                 read_reg2, read_data2, model[read_reg1], model[read_reg2]);
      end
      tick();
      tests++;
      if (read_data1 !== model[read_reg1] || read_data2 !== model[read_reg2]) begin
        fails++;
        $display("FAIL rand_post n=%0d r%0d=%h r%0d=%h want %h/%h", n, read_reg1, read_data1,
                 read_reg2, read_data2, model[read_reg1], model[read_reg2]);
      end
    end
    rst = 1'b0; regwrite = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) model[i] = '0;
    @(negedge clk);
    test_reset();
    test_basic_write();
    test_second_write();
    test_we_low();
    test_r0();
    test_same_cycle_and_reset_priority();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- General-purpose register file for the KGP miniRISC processor datapath.
- Organised as 32 registers of 32 bits each.
- Provides two asynchronous (combinational) read ports and one synchronous write port.
- Sits between instruction decode (register addresses) and the ALU / writeback stage (data).

Parameters:
- DATA_WIDTH, 32, width of each register and of all data ports.
- ADDR_WIDTH, 5, register address width; number of registers = 2**ADDR_WIDTH (32).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- write_data  input  DATA_WIDTH  data to write into register write_reg.
- write_reg  input  ADDR_WIDTH  destination register index.
- regwrite  input  1  write enable, active high.
- read_reg1  input  ADDR_WIDTH  register index for read port 1.
- read_reg2  input  ADDR_WIDTH  register index for read port 2.
- read_data1  output  DATA_WIDTH  contents of register read_reg1.
- read_data2  output  DATA_WIDTH  contents of register read_reg2.

Behaviour:
- Reset:
  - On a rising clk edge with rst=1, all 32 registers are cleared to 0.
  - Reset has priority over regwrite; any write requested in the same cycle is discarded.
  - During and after reset, read_data1/read_data2 = 0 for every address.
- Write:
  - On a rising clk edge with rst=0 and regwrite=1, register[write_reg] <= write_data.
  - With regwrite=0 no register changes; write_reg and write_data are don't-care.
- Register 0:
  - Hardwired to zero. Writes to index 0 are ignored.
  - Reads of index 0 always return 0.
- Read:
  - Purely combinational: read_dataN = register[read_regN], zero latency.
  - Outputs follow address changes within the same cycle.
- Write/read to the same index in the same cycle:
  - No bypass. Before the edge the read port returns the old value.
  - Immediately after the rising edge it returns the newly written value.
- Both read ports may address the same register simultaneously; both return the identical value.
- Before the first reset, register contents are undefined. Power-up state is not relied upon.
- Indices 1..31 are all fully writable; no other reserved registers.
- No X propagation from unused inputs when regwrite=0.

Test Plan:
- Reset:
  - Stimulus: hold rst=1 for one edge after writing 0xDEADBEEF to r5 and 35 to r12.
  - Required response: read_reg1=5, read_reg2=12 give 0 and 0.
- Basic write/read:
  - Stimulus: rst=0, regwrite=1, write_reg=12, write_data=35, read_reg1=12, read_reg2=1.
  - Required response after the edge: read_data1=35, read_data2=0.
- Second write, first preserved:
  - Stimulus: next cycle write_reg=8, write_data=9, read_reg1=12, read_reg2=3.
  - Required response: read_data1=35, read_data2=0. Then read_reg2=8 returns 9 combinationally.
- Write-enable low:
  - Stimulus: regwrite=0, write_reg=12, write_data=77, clock edge.
  - Required response: read_reg1=12 still returns 35.
- Register 0:
  - Stimulus: regwrite=1, write_reg=0, write_data=123, clock edge.
  - Required response: read_reg1=0 returns 0.
- Same-cycle read/write and reset priority:
  - Stimulus: write_reg=20, write_data=0xFFFFFFFF, read_reg1=20.
  - Required response: old value 0 before the edge, 0xFFFFFFFF after it.
  - Then assert rst=1 together with regwrite=1, write_reg=20, write_data=5.
  - Required response: read_data1=0 after the edge.
